// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue bus: fetch push side, decode pop side, redirect flush and occupancy.
// master = fetch/decode environment, slave = the queue itself.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  logic                     in_valid;
  logic [31:0]              in_pc;
  logic [31:0]              in_instr;
  logic                     in_ready;
  logic                     out_valid;
  logic [31:0]              out_pc;
  logic [31:0]              out_instr;
  logic                     out_ready;
  logic                     flush;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output in_valid, in_pc, in_instr, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_instr, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready, flush,
    output in_ready, out_valid, out_pc, out_instr, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular {pc, instr} FIFO between fetch and decode; flush drops every queued entry.
// Optional FETCHQ_ALIGN_CHK_EN adds a sticky misalign_err for pushes with pc[1:0] != 0.
module fetch_queue #(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.slave  q
`ifdef FETCHQ_ALIGN_CHK_EN
  , output logic        misalign_err
`endif
);
  localparam logic [31:0] NOP = 32'h00000013;

  logic [31:0]      mem_pc    [DEPTH];
  logic [31:0]      mem_instr [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             in_ready;
  logic             out_valid;
  logic             push;
  logic             pop;

  // Full/empty come only from the registered count, never from flush or the inputs.
  assign in_ready    = (count != CNT_W'(DEPTH));
  assign out_valid   = (count != '0);
  assign push        = q.in_valid & in_ready;
  assign pop         = out_valid & q.out_ready;

  assign q.in_ready  = in_ready;
  assign q.out_valid = out_valid;
  assign q.count     = count;
  assign q.out_pc    = out_valid ? mem_pc[rd_ptr]    : '0;
  assign q.out_instr = out_valid ? mem_instr[rd_ptr] : NOP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (q.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not cleared on flush; the zeroed pointers hide stale entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]    <= '0;
        mem_instr[i] <= '0;
      end
    end else if (push && !q.flush) begin
      mem_pc[wr_ptr]    <= q.in_pc;
      mem_instr[wr_ptr] <= q.in_instr;
    end
  end

`ifdef FETCHQ_ALIGN_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 misalign_err <= 1'b0;
    else if (q.flush)                        misalign_err <= 1'b0;
    else if (push && (q.in_pc[1:0] != 2'b00)) misalign_err <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic against a queue-based model.
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();
`ifdef FETCHQ_ALIGN_CHK_EN
  logic misalign_err;
`endif

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus)
`ifdef FETCHQ_ALIGN_CHK_EN
    , .misalign_err (misalign_err)
`endif
  );

  logic [63:0] mq [$];
  bit          m_err;
  int          nvec;
  int          nerr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("in_ready",  64'(bus.in_ready),  64'(mq.size() != DEPTH));
    chk("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
    chk("count",     64'(bus.count),     64'(mq.size()));
    chk("out_pc",    64'(bus.out_pc),    mq.size() != 0 ? {32'h0, mq[0][63:32]} : 64'h0);
    chk("out_instr", 64'(bus.out_instr), mq.size() != 0 ? {32'h0, mq[0][31:0]} : 64'h13);
    chk("empty_implies_invalid", 64'(bus.count == 0 && bus.out_valid), 64'h0);
`ifdef FETCHQ_ALIGN_CHK_EN
    chk("misalign_err", 64'(misalign_err), 64'(m_err));
`endif
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                       input bit rdy, input bit fl);
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_instr  = ins;
    bus.out_ready = rdy;
    bus.flush     = fl;
  endtask

  // Called at a negedge with inputs already driven; advances one clock and the model.
  task automatic step();
    bit do_push, do_pop;
    check_outputs();
    do_push = bus.in_valid && (mq.size() < DEPTH);
    do_pop  = bus.out_ready && (mq.size() > 0);
    @(posedge clk);
    if (bus.flush) begin
      mq.delete();
      m_err = 1'b0;
    end else begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) begin
        mq.push_back({bus.in_pc, bus.in_instr});
        if (bus.in_pc[1:0] != 2'b00) m_err = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] addi(input int i);
    return 32'h00000093 | (32'(i) << 20);
  endfunction

  initial begin
    nvec  = 0;
    nerr  = 0;
    m_err = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Reset then idle
    rst = 1'b1;
    #1;
    check_outputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_outputs();
    step();

    // Fill with decode stalled, then a fifth push that must be ignored
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i), addi(i + 1), 1'b0, 1'b0);
      step();
    end
    chk("fill_count", 64'(bus.count), 64'd4);
    chk("fill_in_ready", 64'(bus.in_ready), 64'd0);
    drive(1'b1, 32'h10, addi(5), 1'b0, 1'b0);
    step();
    chk("fifth_push_ignored", 64'(bus.count), 64'd4);

    // Drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("drain_pc", 64'(bus.out_pc), 64'(4 * i));
      chk("drain_instr", 64'(bus.out_instr), 64'(addi(i + 1)));
      step();
    end
    chk("drained_out_valid", 64'(bus.out_valid), 64'd0);

    // Hold count=2 with a push and pop every cycle; pointers wrap
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'(4 * i), addi(i), 1'b0, 1'b0);
      step();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(4 * (i + 2)), addi(i + 2), 1'b1, 1'b0);
      chk("wrap_pop_pc", 64'(bus.out_pc), 64'(4 * i));
      step();
      chk("wrap_count", 64'(bus.count), 64'd2);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    step();

    // Flush during a push at count=3
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h300 + 32'(4 * i), addi(i), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 32'h100, addi(9), 1'b0, 1'b1);
    step();
    chk("flush_count", 64'(bus.count), 64'd0);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    drive(1'b1, 32'h200, addi(7), 1'b0, 1'b0);
    step();
    chk("after_flush_head", 64'(bus.out_pc), 64'h200);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();

    // Asynchronous reset between edges with count=2
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h400 + 32'(4 * i), addi(i), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    mq.delete();
    m_err = 1'b0;
    chk("async_rst_count", 64'(bus.count), 64'd0);
    chk("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    step();

`ifdef FETCHQ_ALIGN_CHK_EN
    drive(1'b1, 32'h102, addi(1), 1'b0, 1'b0);
    step();
    chk("misalign_set", 64'(misalign_err), 64'd1);
    drive(1'b1, 32'h104, addi(2), 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h108, addi(3), 1'b1, 1'b0);
    step();
    chk("misalign_sticky", 64'(misalign_err), 64'd1);
    drive(1'b1, 32'h10e, addi(4), 1'b0, 1'b1);
    step();
    chk("misalign_flush_clear", 64'(misalign_err), 64'd0);
`endif

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom(), $urandom(),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
      step();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    repeat (DEPTH + 1) step();
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch queue between the fetch stage (program counter plus instruction ROM) and decode.
- Captures each fetched {pc, instruction} pair into a small circular FIFO.
- Hands entries to decode under a valid/ready handshake.
- Back-pressures fetch when full, so the program counter can be held.
- Drops all queued entries on a redirect (branch/jump flush).

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  fetch presents a valid pc/instruction pair this cycle.
- in_pc  input  32  address of the fetched instruction.
- in_instr  input  32  instruction word read from ROM at in_pc.
- in_ready  output  1  queue can accept a push this cycle.
- out_valid  output  1  head entry is valid for decode.
- out_pc  output  32  pc of head entry.
- out_instr  output  32  instruction of head entry.
- out_ready  input  1  decode consumes head this cycle.
- flush  input  1  redirect; discard all entries.
- count  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset (asynchronous, active-high; applies mid-operation as well):
  - wr_ptr, rd_ptr and count go to 0.
  - All storage entries cleared to pc=0, instr=0.
  - Outputs while in reset and after: in_ready=1, out_valid=0, out_pc=0, out_instr=32'h00000013, count=0.
- Push: occurs when in_valid && in_ready. Writes {in_pc, in_instr} at wr_ptr; wr_ptr increments.
- Pop: occurs when out_valid && out_ready. rd_ptr increments.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap modulo DEPTH naturally (DEPTH-1 -> 0).
- Full/empty from count only: in_ready = (count != DEPTH); out_valid = (count != 0). Both are combinational from registered count.
- No fall-through: a pushed entry appears at the output one cycle after the push edge, at the earliest.
- Output data:
  - When out_valid=1: out_pc/out_instr come combinationally from the entry at rd_ptr.
  - When out_valid=0: out_pc=0 and out_instr=32'h00000013 (canonical NOP addi x0,x0,0).
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Simultaneous push and pop: count unchanged; both pointers advance.
- Full: in_ready=0, so no push occurs. Pop still allowed; in_ready rises the cycle after a pop from full.
- Empty: out_valid=0, so no pop occurs regardless of out_ready. A push in that cycle makes count 1.
- Flush has priority over push and pop in the same cycle. At the next edge:
  - wr_ptr=rd_ptr=0 and count=0.
  - Any same-cycle push is discarded.
  - Storage contents need not be cleared.
  - in_ready/out_valid do not depend combinationally on flush.
- count never exceeds DEPTH and never underflows. Verification asserts this, plus (count==0) -> !out_valid.

Optional Feature:
- Macro: FETCHQ_ALIGN_CHK_EN.
- Defined:
  - Adds output misalign_err (1 bit, registered, sticky).
  - Set at the edge where a push occurs with in_pc[1:0] != 2'b00.
  - Cleared by rst or flush; flush wins over a same-cycle set.
  - The offending entry is still queued normally.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Reset then idle: assert rst, release -> in_ready=1, out_valid=0, count=0, out_instr=32'h00000013, out_pc=0.
- Fill/drain (DEPTH=4), out_ready=0:
  - Push pc 0x0,0x4,0x8,0xC with instrs 0x00100093..0x00400093 -> count=4 and in_ready=0; a 5th push is ignored.
  - Then out_ready=1 -> pops in order 0x0,0x4,0x8,0xC; out_valid=0 after the 4th pop.
- Wrap and simultaneous push/pop:
  - Hold count=2 while pushing and popping every cycle for 10 cycles.
  - Required: count stays 2, pops return consecutive pcs 0x0..0x24 in order, pointers wrap with no loss.
- Flush during a push at count=3: next cycle count=0, out_valid=0, and the pushed pc 0x100 is never output. The next push, pc 0x200, is output first.
- Asynchronous reset mid-stream: with count=2, pulse rst between clock edges -> count=0, out_valid=0 immediately, without waiting for a clock edge.
- With FETCHQ_ALIGN_CHK_EN:
  - Push pc 0x102 -> misalign_err=1 after the edge; it stays 1 through later aligned pushes.
  - flush -> misalign_err=0 next edge.
